// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader
//
// Configuration-chain controller for one routing-tile region. Configuration
// words arrive on a valid/ready stream. Each word is serialised MSB-first onto
// ccff_head while ccff_shift_en gates prog_clk to the chain through the tile
// ICG. The old chain contents leaving at ccff_tail are collected into
// left-aligned readback words. A completed load issues exactly CHAIN_LEN shift
// cycles. Low bits of the final word that do not fit in the chain are dropped.
//
// Ports:
//   prog_clk      configuration clock; all state changes on the rising edge
//   pReset        synchronous, active-low reset
//   start         begin a load (sampled in IDLE only)
//   abort         synchronous cancel back to IDLE; no done pulse
//   cfg_data      configuration word, MSB shifted first
//   cfg_valid     cfg_data valid
//   cfg_ready     controller accepts cfg_data this cycle (decoded from state)
//   ccff_head     serial data into the chain (0 whenever not shifting)
//   ccff_shift_en chain advances one bit at the next edge
//   ccff_tail     serial data leaving the chain
//   rb_data       readback word, first-out bit in the MSB
//   rb_valid      one-cycle strobe qualifying rb_data
//   busy          high while fetching or shifting
//   done          one-cycle pulse when a load completes
module ccff_chain_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 58
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int NB_W  = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SHIFT,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WORD_W-1:0] shift_reg;
    logic [WORD_W-1:0] rb_reg;
    logic [WORD_W-1:0] rb_shifted;
    logic [CNT_W-1:0]  bitcnt;
    logic [CNT_W-1:0]  remaining;
    logic [NB_W-1:0]   nbits;
    logic [NB_W-1:0]   load_nbits;
    logic [NB_W-1:0]   wcnt;
    logic              last_bit;
    logic              chain_full;

    // Bits of the next word that still fit in the chain; only the final
    // word of a load can be shorter than WORD_W.
    always_comb begin
        remaining = CNT_W'(CHAIN_LEN) - bitcnt;
        if (int'(remaining) >= WORD_W) begin
            load_nbits = NB_W'(WORD_W);
        end else begin
            load_nbits = NB_W'(remaining);
        end
    end

    assign last_bit   = (wcnt == nbits - NB_W'(1));
    assign chain_full = (bitcnt == CNT_W'(CHAIN_LEN - 1));
    assign rb_shifted = (rb_reg << 1) | WORD_W'(ccff_tail);

    // State register.
    always_ff @(posedge prog_clk) begin
        if (!pReset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and state-decoded outputs. Abort overrides every transition.
    always_comb begin
        state_next    = state;
        cfg_ready     = 1'b0;
        ccff_shift_en = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                cfg_ready = 1'b1;
                busy      = 1'b1;
                if (cfg_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                ccff_shift_en = 1'b1;
                busy          = 1'b1;
                if (last_bit) begin
                    state_next = chain_full ? DONE : FETCH;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (abort) begin
            state_next = IDLE;
        end
        ccff_head = ccff_shift_en & shift_reg[WORD_W-1];
    end

    // Datapath: word load, serialisation, readback capture. The readback
    // strobe for the final bit of a word is dropped if that cycle aborts.
    always_ff @(posedge prog_clk) begin
        if (!pReset) begin
            shift_reg <= '0;
            rb_reg    <= '0;
            rb_data   <= '0;
            rb_valid  <= 1'b0;
            bitcnt    <= '0;
            nbits     <= '0;
            wcnt      <= '0;
        end else begin
            rb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    bitcnt <= '0;
                end
                FETCH: begin
                    if (cfg_valid && !abort) begin
                        shift_reg <= cfg_data;
                        nbits     <= load_nbits;
                        wcnt      <= '0;
                        rb_reg    <= '0;
                    end
                end
                SHIFT: begin
                    shift_reg <= shift_reg << 1;
                    rb_reg    <= rb_shifted;
                    bitcnt    <= bitcnt + CNT_W'(1);
                    wcnt      <= wcnt + NB_W'(1);
                    if (last_bit && !abort) begin
                        rb_valid <= 1'b1;
                        rb_data  <= rb_shifted << (WORD_W - int'(nbits));
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
